// File: rtl/aria_sl_core.sv
// aria_sl_core: multi-lane ARIA substitution layer (SL1/SL2) over a 128-bit state.
// LANES bytes per cycle; each lane is a 4-way sbox built around a shared GF(2^8) inverse.
module aria_sl_core #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_sl2,
    input  logic         abort,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int BEATS = (LANES > 0) ? 16 / LANES : 1;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
        $error("aria_sl_core: LANES must be 1, 2, 4, 8 or 16");
    end

    // Linear maps as column sets: entry i is the image of input bit i.
    // S2's matrix already folds in the x^8 Frobenius, so it applies directly to x^-1.
    typedef logic [7:0][7:0] cols_t;
    localparam cols_t A_FWD = {8'h8f, 8'hc7, 8'he3, 8'hf1, 8'hf8, 8'h7c, 8'h3e, 8'h1f};
    localparam cols_t A_INV = {8'h25, 8'h92, 8'h49, 8'ha4, 8'h52, 8'h29, 8'h94, 8'h4a};
    localparam cols_t M_FWD = {8'h5f, 8'hfb, 8'ha7, 8'h26, 8'h83, 8'hc6, 8'hfd, 8'hac};
    localparam cols_t M_INV = {8'he8, 8'hae, 8'h52, 8'h75, 8'hc1, 8'h7a, 8'h38, 8'hd8};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 = x^-1 (and 0 -> 0), built from x^2 * x^4 * ... * x^128.
    function automatic logic [7:0] aria_lt_gfinv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] lin_map(input logic [7:0] x, input cols_t cols);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) r = r ^ cols[i];
        end
        return r;
    endfunction

    // sel[0] picks the S2 family, sel[1] picks the inverse direction.
    function automatic logic [7:0] sbox4(input logic [7:0] x, input logic [1:0] sel);
        logic [7:0] c;
        logic [7:0] pre;
        logic [7:0] g;
        c   = sel[0] ? 8'he2 : 8'h63;
        pre = sel[1] ? lin_map(x ^ c, sel[0] ? M_INV : A_INV) : x;
        g   = aria_lt_gfinv(pre);
        return sel[1] ? g : (lin_map(g, sel[0] ? M_FWD : A_FWD) ^ c);
    endfunction

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [127:0]    st_q;
    logic [127:0]    st_next;
    logic            sl2_q;
    logic            last_beat;
    logic [7:0]      lane_out [LANES];
    logic [3:0]      lane_idx [LANES];

    assign last_beat = (cnt_q == CW'(BEATS - 1));

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [7:0] din;
        assign lane_idx[j] = 4'(int'(cnt_q) * LANES + j);
        assign din         = st_q[8*(15 - int'(lane_idx[j])) +: 8];
        assign lane_out[j] = sbox4(din, lane_idx[j][1:0] ^ {sl2_q, 1'b0});
    end

    always_comb begin
        st_next = st_q;
        for (int j = 0; j < LANES; j++) begin
            st_next[8*(15 - int'(lane_idx[j])) +: 8] = lane_out[j];
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = RUN;
            RUN: begin
                if (abort) state_d = IDLE;
                else if (last_beat) state_d = DONE;
            end
            DONE: begin
                if (abort) state_d = IDLE;
                else if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            st_q  <= '0;
            sl2_q <= 1'b0;
        end else if (state_q == IDLE) begin
            if (in_valid) begin
                st_q  <= in_data;
                sl2_q <= in_sl2;
                cnt_q <= '0;
            end
        end else if (state_q == RUN && !abort) begin
            st_q  <= st_next;
            cnt_q <= last_beat ? '0 : cnt_q + 1'b1;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign out_data  = st_q;

endmodule
